// File: rtl/spi_peek_pkg.sv
// Shared types and limits for the SPI peek master.
// Contents:
//   spi_master_state_t - transaction state encoding
//   SPI_MIN_*          - lower limits checked at elaboration
//   spi_max()          - elaboration-time helper for counter sizing
package spi_peek_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LO    = 3'd2,
    ST_HI    = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_master_state_t;

  localparam int unsigned SPI_MIN_CLK_DIV   = 4;
  localparam int unsigned SPI_MIN_CS_SETUP  = 1;
  localparam int unsigned SPI_MIN_PEEK_BITS = 2;

  function automatic int unsigned spi_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_tick_counter.sv
// Loadable down-counter that times every state of the SPI peek master.
// A loaded value L gives a state that lasts L+1 cycles; tc_c marks the final one.
// Ports:
//   clk, rst   - clock, async active-high reset
//   load       - load load_val this cycle
//   load_val   - value to load
//   count      - current count (registered)
//   tc_c       - combinational terminal-count flag (count == 0)
module spi_tick_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc_c
);

  // Count down and park at zero until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/spi_peek_master.sv
// SPI mode-0 master running one fixed-length full-duplex "peek" transfer per start.
// SCLK is paced slowly enough for a slave that oversamples SCLK/SEL_/MOSI through
// 3-stage synchronisers.
// Ports:
//   clk, rst  - clock, async active-high reset
//   start     - request a transfer (only sampled in IDLE)
//   data_in   - word to send, MSB first, latched when start is accepted
//   data_out  - word received, updated on the done cycle
//   busy      - transfer or SEL_ gap in progress
//   done      - one-cycle end-of-transfer pulse
//   ucSCLK, ucMOSI, ucSEL_ - SPI pins driven to the slave
//   ucMISO    - SPI data from the slave (sampled unsynchronised; stable at sample)
// Build option: define SPI_PEEK_MASTER_LOOPBACK_EN to sample ucMOSI internally in
// place of ucMISO, so data_out mirrors data_in; pin timing is unchanged.
module spi_peek_master
  import spi_peek_pkg::*;
#(
  parameter int unsigned PEEK_BITS = 64,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_SETUP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PEEK_BITS-1:0] data_in,
  output logic [PEEK_BITS-1:0] data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 ucSCLK,
  output logic                 ucMOSI,
  input  logic                 ucMISO,
  output logic                 ucSEL_
);

  localparam int unsigned TICK_MAX = spi_max(CLK_DIV, CS_SETUP);
  localparam int unsigned CNT_W    = $clog2(TICK_MAX);
  localparam int unsigned BIT_W    = $clog2(PEEK_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CS_LOAD  = CNT_W'(CS_SETUP - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PEEK_BITS - 1);
  localparam bit               GAP_ONE  = (CS_SETUP == 1);

  // Elaboration-time parameter checks.
  if (PEEK_BITS < SPI_MIN_PEEK_BITS) begin : g_chk_bits
    $error("spi_peek_master: PEEK_BITS must be >= %0d", SPI_MIN_PEEK_BITS);
  end
  if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_chk_div
    $error("spi_peek_master: CLK_DIV must be >= %0d", SPI_MIN_CLK_DIV);
  end
  if (CS_SETUP < SPI_MIN_CS_SETUP) begin : g_chk_cs
    $error("spi_peek_master: CS_SETUP must be >= %0d", SPI_MIN_CS_SETUP);
  end

  spi_master_state_t    state;
  logic [PEEK_BITS-1:0] tx;
  logic [PEEK_BITS-1:0] rx;
  logic [BIT_W-1:0]     bit_cnt;

  logic [CNT_W-1:0]     tick_cnt;
  logic                 tick_tc_c;
  logic                 tick_load_c;
  logic [CNT_W-1:0]     tick_val_c;
  logic                 miso_bit_c;
  logic                 done_next_c;

  // MOSI is the MSB of the transmit shift register.
  assign ucMOSI = tx[PEEK_BITS-1];

`ifdef SPI_PEEK_MASTER_LOOPBACK_EN
  // Loopback: the sample point sees the bit currently on ucMOSI.
  logic unused_miso_c;
  assign unused_miso_c = ucMISO;
  assign miso_bit_c    = tx[PEEK_BITS-1];
`else
  assign miso_bit_c    = ucMISO;
`endif

  spi_tick_counter #(
    .WIDTH (CNT_W)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (tick_load_c),
    .load_val (tick_val_c),
    .count    (tick_cnt),
    .tc_c     (tick_tc_c)
  );

  // Reload the tick counter on every state transition with the next state's length.
  always_comb begin
    tick_load_c = 1'b0;
    tick_val_c  = CS_LOAD;
    case (state)
      ST_IDLE: begin
        if (start) begin
          tick_load_c = 1'b1;
          tick_val_c  = CS_LOAD;
        end
      end
      ST_SETUP, ST_LO: begin
        if (tick_tc_c) begin
          tick_load_c = 1'b1;
          tick_val_c  = DIV_LOAD;
        end
      end
      ST_HI: begin
        if (tick_tc_c) begin
          tick_load_c = 1'b1;
          tick_val_c  = (bit_cnt == LAST_BIT) ? CS_LOAD : DIV_LOAD;
        end
      end
      ST_HOLD: begin
        if (tick_tc_c) begin
          tick_load_c = 1'b1;
          tick_val_c  = CS_LOAD;
        end
      end
      default: ;
    endcase
  end

  // done is registered, so it is raised on entry to the final GAP cycle. With a
  // one-cycle gap that entry is the HOLD->GAP edge itself.
  assign done_next_c = (GAP_ONE && (state == ST_HOLD) && tick_tc_c) ||
                       ((state == ST_GAP) && (tick_cnt == CNT_W'(1)));

  // Transaction FSM with registered pin and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx       <= '0;
      rx       <= '0;
      bit_cnt  <= '0;
      ucSCLK   <= 1'b0;
      ucSEL_   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      if (done_next_c) begin
        done     <= 1'b1;
        busy     <= 1'b0;
        data_out <= rx;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            tx      <= data_in;
            rx      <= '0;
            bit_cnt <= '0;
            ucSEL_  <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (tick_tc_c) state <= ST_LO;
        end

        // MISO is captured in the cycle just before the rising edge.
        ST_LO: begin
          if (tick_tc_c) begin
            rx     <= {rx[PEEK_BITS-2:0], miso_bit_c};
            ucSCLK <= 1'b1;
            state  <= ST_HI;
          end
        end

        // Falling edge: advance MOSI unless this was the last bit.
        ST_HI: begin
          if (tick_tc_c) begin
            ucSCLK  <= 1'b0;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= ST_HOLD;
            end else begin
              tx    <= {tx[PEEK_BITS-2:0], 1'b0};
              state <= ST_LO;
            end
          end
        end

        ST_HOLD: begin
          if (tick_tc_c) begin
            ucSEL_ <= 1'b1;
            state  <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (tick_tc_c) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
